// File: rtl/pcm_dac_pkg.sv
// Shared constants and the integrator saturation helper for the PCM sigma-delta DAC.
// The optional dither path is enabled by defining PCM_DAC_DITHER_EN.
package pcm_dac_pkg;

  localparam int          ACC_W_DEF = 24;
  localparam int          HALF_FS   = 1 << 18;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois mask for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Symmetric clamp to +-(2^(acc_w-1)-1); callers widen their sums to 64 bits first.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int acc_w);
    logic signed [63:0] lim;
    lim = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    if (v > lim)       sat = lim;
    else if (v < -lim) sat = -lim;
    else               sat = v;
  endfunction

endpackage

// File: rtl/pcm_dac_dither_lfsr.sv
// 16-bit Galois LFSR supplying the quantizer dither; present only when PCM_DAC_DITHER_EN is defined.
`ifdef PCM_DAC_DITHER_EN
module pcm_dac_dither_lfsr
  import pcm_dac_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ena,
  output logic [7:0] rnd
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (!reset_n)  lfsr_q <= LFSR_SEED;
    else if (ena)  lfsr_q <= lfsr_d;
  end

  assign rnd = lfsr_q[7:0];

endmodule
`endif

// File: rtl/pcm_sigma_delta_dac.sv
// Second-order sigma-delta modulator: 20-bit unsigned PCM in, 1-bit PDM out.
// Define PCM_DAC_DITHER_EN to add LFSR dither at the quantizer compare.
module pcm_sigma_delta_dac
  import pcm_dac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_ena,
  input  logic [19:0] pcm_in,
  output logic        dac_out
);

  // Two guard bits let acc + x - fb be formed exactly before clamping.
  localparam int                W      = ACC_W + 2;
  localparam logic signed [W-1:0] HALF_W = W'(HALF_FS);
  localparam logic signed [W-1:0] ZERO_W = '0;

  logic signed [ACC_W-1:0] acc1_q, acc1_d;
  logic signed [ACC_W-1:0] acc2_q, acc2_d;
  logic                    dac_q, dac_d;
  logic signed [W-1:0]     x_w, fb_w, sum1_w, sum2_w, quant_w, dith_w;
  logic                    unused_pcm_msb;

  assign unused_pcm_msb = pcm_in[19];

`ifdef PCM_DAC_DITHER_EN
  logic [7:0] rnd;

  pcm_dac_dither_lfsr u_dither (
    .clk     (clk),
    .reset_n (reset_n),
    .ena     (clk_ena),
    .rnd     (rnd)
  );

  assign dith_w = W'($signed(rnd));
`else
  assign dith_w = ZERO_W;
`endif

  always_comb begin
    x_w     = $signed(W'(pcm_in[18:0])) - HALF_W;
    fb_w    = dac_q ? HALF_W : -HALF_W;
    sum1_w  = W'(acc1_q) + x_w - fb_w;
    acc1_d  = ACC_W'(sat(64'(sum1_w), ACC_W));
    sum2_w  = W'(acc2_q) + W'(acc1_d) - fb_w;
    acc2_d  = ACC_W'(sat(64'(sum2_w), ACC_W));
    // Dither only perturbs the decision; it never enters the integrators.
    quant_w = W'(acc2_d) + dith_w;
    dac_d   = (quant_w >= ZERO_W);
  end

  // NOTE: reset is sampled on the clock edge and state uses non-blocking assignments so all
  // three registers update together from the previous cycle's values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc1_q <= '0;
      acc2_q <= '0;
      dac_q  <= 1'b0;
    end else if (clk_ena) begin
      acc1_q <= acc1_d;
      acc2_q <= acc2_d;
      dac_q  <= dac_d;
    end
  end

  assign dac_out = dac_q;

endmodule

// File: tb/tb_pcm_sigma_delta_dac.sv
// Self-checking bench for pcm_sigma_delta_dac: density table, reset, gating, restart and random streams.
module tb_pcm_sigma_delta_dac;

  localparam int     ACC_W = 24;
  localparam longint HALF  = 64'sd1 << 18;
  localparam longint LIM   = (64'sd1 << (ACC_W - 1)) - 64'sd1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_ena = 1'b0;
  logic [19:0] pcm_in = '0;
  logic        dac_out;

  pcm_sigma_delta_dac #(.ACC_W(ACC_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_ena (clk_ena),
    .pcm_in  (pcm_in),
    .dac_out (dac_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference model: plain integer arithmetic on the modulator equations.
  typedef struct {
    longint      a1;
    longint      a2;
    bit          dac;
    logic [15:0] lfsr;
  } mstate_t;

  function automatic longint clamp(input longint v);
    if (v > LIM)  return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  function automatic mstate_t mreset();
    mstate_t s;
    s.a1 = 0; s.a2 = 0; s.dac = 1'b0; s.lfsr = 16'hACE1;
    return s;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input logic [19:0] pcm);
    mstate_t r;
    longint  x, fb, d;
    x  = longint'(pcm[18:0]) - HALF;
    fb = s.dac ? HALF : -HALF;
    r.a1 = clamp(s.a1 + x - fb);
    r.a2 = clamp(s.a2 + r.a1 - fb);
    d = 0;
    r.lfsr = s.lfsr;
`ifdef PCM_DAC_DITHER_EN
    d = longint'($signed(s.lfsr[7:0]));
    r.lfsr = s.lfsr[0] ? ((s.lfsr >> 1) ^ 16'hB400) : (s.lfsr >> 1);
`endif
    r.dac = (r.a2 + d >= 0);
    return r;
  endfunction

  mstate_t m;
  int      step_err;
  longint  max_abs;

  // One clock: apply inputs, advance model, compare DUT state to the model.
  task automatic tick(input bit rst_n, input bit ena, input logic [19:0] pcm);
    longint a1, a2;
    reset_n = rst_n; clk_ena = ena; pcm_in = pcm;
    @(posedge clk); #1;
    if (!rst_n)   m = mreset();
    else if (ena) m = mstep(m, pcm);
    a1 = dut.acc1_q;
    a2 = dut.acc2_q;
    if (dac_out !== m.dac || a1 != m.a1 || a2 != m.a2) step_err++;
    if (a1 > max_abs)  max_abs = a1;
    if (-a1 > max_abs) max_abs = -a1;
    if (a2 > max_abs)  max_abs = a2;
    if (-a2 > max_abs) max_abs = -a2;
  endtask

  typedef struct {
    logic [19:0] pcm;
    int          steps;
    int          ena_div;
    int          ones_lo;
    int          ones_hi;
    int          run_max;
    int          skip;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs[NV];

  initial begin
    int          ones, run, longest, prev, diffs;
    logic [19:0] p;
    bit          ref_bits[200];
    mstate_t     r;

`ifdef PCM_DAC_DITHER_EN
    vecs[0] = '{20'h40000, 8192, 4, 4064, 4128, 8192, 0};
`else
    vecs[0] = '{20'h40000, 8192, 4, 4064, 4128, 4, 0};
`endif
    vecs[1] = '{20'h20000, 8192, 1, 2016, 2080, 8192, 0};
    vecs[2] = '{20'h60000, 8192, 1, 6112, 6176, 8192, 0};
    vecs[3] = '{20'h00000, 4096, 1, 0, 0, 4096, 64};
    vecs[4] = '{20'h7FFFF, 4096, 1, 4000, 4032, 4096, 64};
    vecs[5] = '{20'hC0000, 2048, 1, 1008, 1040, 2048, 0};

    m = mreset();

    // Reset held with enable active and full-scale input.
    step_err = 0; max_abs = 0;
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 20'h7FFFF);
    check("reset_hold_stream", step_err, 0);
    check("reset_dac", dac_out, 0);
    check("reset_acc1", dut.acc1_q, 0);
    check("reset_acc2", dut.acc2_q, 0);

    // Density table.
    for (int v = 0; v < NV; v++) begin
      step_err = 0; max_abs = 0; ones = 0; run = 0; longest = 0; prev = 2;
      tick(1'b0, 1'b0, vecs[v].pcm);
      tick(1'b0, 1'b0, vecs[v].pcm);
      for (int i = 0; i < vecs[v].steps; i++) begin
        for (int k = 0; k < vecs[v].ena_div - 1; k++) tick(1'b1, 1'b0, vecs[v].pcm);
        tick(1'b1, 1'b1, vecs[v].pcm);
        if (i >= vecs[v].skip) begin
          ones += int'(dac_out);
          run = (int'(dac_out) == prev) ? run + 1 : 1;
          prev = int'(dac_out);
          if (run > longest) longest = run;
        end
      end
      check($sformatf("vec%0d_stream", v), step_err, 0);
      check_range($sformatf("vec%0d_ones", v), ones, vecs[v].ones_lo, vecs[v].ones_hi);
      check_range($sformatf("vec%0d_run", v), longest, 1, vecs[v].run_max);
      check_range($sformatf("vec%0d_acc_bound", v), max_abs, 0, LIM);
    end

    // Enable gating: freeze 100 clocks while the input wanders, then resume.
    step_err = 0;
    tick(1'b0, 1'b0, '0);
    p = 20'h31234;
    for (int i = 0; i < 50; i++) tick(1'b1, 1'b1, p);
    for (int i = 0; i < 100; i++) tick(1'b1, 1'b0, 20'($urandom));
    check("gate_dac", dac_out, m.dac);
    check("gate_acc1", dut.acc1_q, m.a1);
    check("gate_acc2", dut.acc2_q, m.a2);
    for (int i = 0; i < 50; i++) tick(1'b1, 1'b1, 20'h5ABCD);
    check("gate_stream", step_err, 0);

    // One-clock reset pulse mid-stream must restart the bit stream from step 0.
    p = 20'h2C000;
    r = mreset();
    for (int i = 0; i < 200; i++) begin
      r = mstep(r, p);
      ref_bits[i] = r.dac;
    end
    step_err = 0;
    for (int i = 0; i < 137; i++) tick(1'b1, 1'b1, p);
    tick(1'b0, 1'b1, p);
    check("pulse_dac", dac_out, 0);
    check("pulse_acc1", dut.acc1_q, 0);
    check("pulse_acc2", dut.acc2_q, 0);
    diffs = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1'b1, 1'b1, p);
      if (dac_out !== ref_bits[i]) diffs++;
    end
    check("restart_stream", diffs, 0);
    check("restart_model", step_err, 0);

    // Random segments: random inputs (bit 19 included), random enable density, occasional reset.
    step_err = 0; max_abs = 0;
    for (int s = 0; s < 40; s++) begin
      p = 20'($urandom);
      if (s == 0 || s == 5 || s == 17) p = (s == 5) ? 20'h00000 : 20'h7FFFF;
      for (int i = 0; i < int'($urandom_range(10, 80)); i++)
        tick(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) != 0), p);
    end
    check("random_stream", step_err, 0);
    check_range("random_acc_bound", max_abs, 0, LIM);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
